// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, coordinate type and sync bus
package vga_timing_pkg;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bus_t;

  // Largest count an 11-bit scan counter can hold; used by the elaboration guard
  function automatic bit fits_coord(input int total);
    return total <= (1 << COORD_W) - 1;
  endfunction

endpackage

// File: rtl/vga_timing_generator_sync_delay_line.sv
// rtl/vga_timing_generator_sync_delay_line.sv - fixed-depth delay for the sync/blank bus
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int        DEPTH   = 1,
  parameter sync_bus_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      reset,
  input  sync_bus_t din,
  output sync_bus_t dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    sync_bus_t stages [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - pixel divider, scan counters and sync/blank decode
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 2,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [10:0]  pixel_x,
  output logic [10:0]  pixel_y,
  output logic         pixel_en,
  output logic         line_start,
  output logic         frame_start,
  output logic         hsync,
  output logic         vsync,
  output logic         video_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL)) begin : g_size_check
    $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end

  localparam logic [1:0] DIV_LAST  = 2'(CLK_DIV - 1);
  localparam coord_t     H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t     V_LAST    = coord_t'(V_TOTAL - 1);
  localparam coord_t     H_ACT     = coord_t'(H_ACTIVE);
  localparam coord_t     V_ACT     = coord_t'(V_ACTIVE);
  localparam coord_t     HS_START  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t     HS_END    = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t     VS_START  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t     VS_END    = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam sync_bus_t  IDLE      = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};

  logic [1:0] div_cnt;
  coord_t     h_cnt;
  coord_t     v_cnt;
  sync_bus_t  dec;
  sync_bus_t  del;

  // Gated by reset so the strobe stays low while held, even when CLK_DIV=1
  assign pixel_en = !reset && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (pixel_en) begin
      div_cnt <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_cnt <= h_cnt + coord_t'(1);
      end
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign line_start  = pixel_en && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

  always_comb begin
    dec        = IDLE;
    dec.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    dec.hsync  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    dec.vsync  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    // Only matters for PIPE_DELAY=0, where the decode drives the pins directly
    if (reset) dec = IDLE;
  end

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (IDLE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (dec),
    .dout  (del)
  );

  assign hsync        = del.hsync;
  assign vsync        = del.vsync;
  assign video_active = del.active;

endmodule
